// File: rtl/zap_wb_merger_pkg.sv
// Shared encodings for the Wishbone merger: arbiter states, cycle-type tags
// and the load operations that the arbiter issues to the output register stage.
package zap_wb_merger_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_T = 2'd1,
    OWN_C = 2'd2
  } owner_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_BURST   = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    OP_CLEAR  = 2'd0,
    OP_LOAD_T = 2'd1,
    OP_LOAD_C = 2'd2
  } mux_op_e;

  // An ack belongs to a master only while that master owns the bus.
  function automatic logic route_ack(input logic ack, input owner_e state, input owner_e who);
    return ack & (state == who);
  endfunction

endpackage

// File: rtl/zap_wb_merger_if.sv
// Wishbone request/bus bundle: the master drives the request fields and
// receives ack; the slave side sees the mirror image.
interface zap_wb_merger_if #(
  parameter int ADR_WDT = 32,
  parameter int DAT_WDT = 32
);

  logic                   cyc;
  logic                   stb;
  logic                   wen;
  logic [DAT_WDT/8-1:0]   sel;
  logic [ADR_WDT-1:0]     adr;
  logic [DAT_WDT-1:0]     dat;
  logic [2:0]             cti;
  logic                   ack;

  modport master (
    output cyc, stb, wen, sel, adr, dat, cti,
    input  ack
  );

  modport slave (
    input  cyc, stb, wen, sel, adr, dat, cti,
    output ack
  );

endinterface

// File: rtl/zap_wb_mux_reg.sv
// Registered Wishbone output stage: loads every bus field from the selected
// master, or drops cyc/stb while keeping the remaining fields.
module zap_wb_mux_reg
  import zap_wb_merger_pkg::*;
#(
  parameter int ADR_WDT = 32,
  parameter int DAT_WDT = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  mux_op_e           op_i,
  zap_wb_merger_if.slave    t_src,
  zap_wb_merger_if.slave    c_src,
  zap_wb_merger_if.master   bus
);

  localparam int SEL_WDT = DAT_WDT / 8;

  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic               wen_q, wen_d;
  logic [SEL_WDT-1:0] sel_q, sel_d;
  logic [ADR_WDT-1:0] adr_q, adr_d;
  logic [DAT_WDT-1:0] dat_q, dat_d;
  logic [2:0]         cti_q, cti_d;

  // NOTE: every _d gets its hold value first, so no path through the case leaves it unassigned (no latch).
  always_comb begin
    cyc_d = cyc_q;
    stb_d = stb_q;
    wen_d = wen_q;
    sel_d = sel_q;
    adr_d = adr_q;
    dat_d = dat_q;
    cti_d = cti_q;
    case (op_i)
      OP_LOAD_T: begin
        cyc_d = t_src.cyc;
        stb_d = t_src.stb;
        wen_d = t_src.wen;
        sel_d = t_src.sel;
        adr_d = t_src.adr;
        dat_d = t_src.dat;
        cti_d = t_src.cti;
      end
      OP_LOAD_C: begin
        cyc_d = c_src.cyc;
        stb_d = c_src.stb;
        wen_d = c_src.wen;
        sel_d = c_src.sel;
        adr_d = c_src.adr;
        dat_d = c_src.dat;
        cti_d = c_src.cti;
      end
      default: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
      end
    endcase
  end

  // NOTE: non-blocking assignments so all flops sample their _d together on the edge.
  // These are plain flops, not a memory, so clearing the whole bus on reset is cheap and keeps it deterministic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      wen_q <= 1'b0;
      sel_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
      cti_q <= CTI_CLASSIC;
    end else begin
      cyc_q <= cyc_d;
      stb_q <= stb_d;
      wen_q <= wen_d;
      sel_q <= sel_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      cti_q <= cti_d;
    end
  end

  assign bus.cyc = cyc_q;
  assign bus.stb = stb_q;
  assign bus.wen = wen_q;
  assign bus.sel = sel_q;
  assign bus.adr = adr_q;
  assign bus.dat = dat_q;
  assign bus.cti = cti_q;

endmodule

// File: rtl/zap_wb_merger.sv
// Merges the TLB walker and cache Wishbone masters onto one registered port;
// ownership is held for a whole bus cycle and ack returns only to the owner.
module zap_wb_merger
  import zap_wb_merger_pkg::*;
#(
  parameter int ADR_WDT = 32,
  parameter int DAT_WDT = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,

  input  logic                 i_c_wb_cyc_nxt,
  input  logic                 i_c_wb_stb_nxt,
  input  logic                 i_c_wb_wen_nxt,
  input  logic [DAT_WDT/8-1:0] i_c_wb_sel_nxt,
  input  logic [ADR_WDT-1:0]   i_c_wb_adr_nxt,
  input  logic [DAT_WDT-1:0]   i_c_wb_dat_nxt,
  input  logic [2:0]           i_c_wb_cti_nxt,
  output logic                 o_c_wb_ack,

  input  logic                 i_t_wb_cyc_nxt,
  input  logic                 i_t_wb_stb_nxt,
  input  logic                 i_t_wb_wen_nxt,
  input  logic [DAT_WDT/8-1:0] i_t_wb_sel_nxt,
  input  logic [ADR_WDT-1:0]   i_t_wb_adr_nxt,
  input  logic [DAT_WDT-1:0]   i_t_wb_dat_nxt,
  output logic                 o_t_wb_ack,

  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_wen,
  output logic [DAT_WDT/8-1:0] o_wb_sel,
  output logic [ADR_WDT-1:0]   o_wb_adr,
  output logic [DAT_WDT-1:0]   o_wb_dat,
  output logic [2:0]           o_wb_cti,
  input  logic [DAT_WDT-1:0]   i_wb_dat,
  input  logic                 i_wb_ack,
  output logic [DAT_WDT-1:0]   o_wb_rdat,

  output logic [1:0]           o_owner
);

  owner_e  state_q, state_d;
  mux_op_e op;

  zap_wb_merger_if #(.ADR_WDT(ADR_WDT), .DAT_WDT(DAT_WDT)) t_req ();
  zap_wb_merger_if #(.ADR_WDT(ADR_WDT), .DAT_WDT(DAT_WDT)) c_req ();
  zap_wb_merger_if #(.ADR_WDT(ADR_WDT), .DAT_WDT(DAT_WDT)) bus   ();

  // The page walker has no burst support, so it always issues classic cycles.
  assign t_req.cyc = i_t_wb_cyc_nxt;
  assign t_req.stb = i_t_wb_stb_nxt;
  assign t_req.wen = i_t_wb_wen_nxt;
  assign t_req.sel = i_t_wb_sel_nxt;
  assign t_req.adr = i_t_wb_adr_nxt;
  assign t_req.dat = i_t_wb_dat_nxt;
  assign t_req.cti = CTI_CLASSIC;

  assign c_req.cyc = i_c_wb_cyc_nxt;
  assign c_req.stb = i_c_wb_stb_nxt;
  assign c_req.wen = i_c_wb_wen_nxt;
  assign c_req.sel = i_c_wb_sel_nxt;
  assign c_req.adr = i_c_wb_adr_nxt;
  assign c_req.dat = i_c_wb_dat_nxt;
  assign c_req.cti = i_c_wb_cti_nxt;

  assign bus.ack   = i_wb_ack;
  assign t_req.ack = route_ack(bus.ack, state_q, OWN_T);
  assign c_req.ack = route_ack(bus.ack, state_q, OWN_C);

  // TLB wins a tie in IDLE: a cache miss cannot finish until translation does.
  // Leaving an owner always passes through IDLE, giving one idle bus cycle.
  always_comb begin
    state_d = state_q;
    op      = OP_CLEAR;
    case (state_q)
      IDLE: begin
        if (t_req.cyc) begin
          state_d = OWN_T;
          op      = OP_LOAD_T;
        end else if (c_req.cyc) begin
          state_d = OWN_C;
          op      = OP_LOAD_C;
        end
      end
      OWN_T: begin
        if (t_req.cyc) op = OP_LOAD_T;
        else           state_d = IDLE;
      end
      OWN_C: begin
        if (c_req.cyc) op = OP_LOAD_C;
        else           state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  zap_wb_mux_reg #(
    .ADR_WDT (ADR_WDT),
    .DAT_WDT (DAT_WDT)
  ) u_mux_reg (
    .clk_i  (i_clk),
    .rst_ni (i_reset),
    .op_i   (op),
    .t_src  (t_req),
    .c_src  (c_req),
    .bus    (bus)
  );

  assign o_wb_cyc   = bus.cyc;
  assign o_wb_stb   = bus.stb;
  assign o_wb_wen   = bus.wen;
  assign o_wb_sel   = bus.sel;
  assign o_wb_adr   = bus.adr;
  assign o_wb_dat   = bus.dat;
  assign o_wb_cti   = bus.cti;
  assign o_wb_rdat  = i_wb_dat;
  assign o_t_wb_ack = t_req.ack;
  assign o_c_wb_ack = c_req.ack;
  assign o_owner    = state_q;

  a_ack_exclusive : assert property (@(posedge i_clk) disable iff (!i_reset)
    !(o_t_wb_ack && o_c_wb_ack));

  a_state_legal : assert property (@(posedge i_clk) disable iff (!i_reset)
    state_q inside {IDLE, OWN_T, OWN_C});

endmodule
